instr_fetch: RTL and testbench

Instruction fetch unit that drives the address side of the instruction ROM (`memory`) and captures the 16-bit word it returns. It sits between `memory` and the decode/execute stage of the lab processor. It holds the program counter, an instruction register with a valid flag, a stall hold, a branch/jump redirect with flush, a HALT stop state and a saturating fetch counter.

---
 rtl/instr_fetch.sv | 72 +++++++
 tb/tb_instr_fetch.sv | 126 ++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: program counter, instruction register, stall/branch handling and HALT stop
module instr_fetch #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_in,
  input  logic              stall,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_addr,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, ir_pc_n;
  logic [DATA_W-1:0] ir_n;
  logic ir_valid_n;
  logic [15:0] count_n;
  logic advance;
  assign instr_addr = pc;
  assign advance = state == RUN && !branch_en && !stall;
  // next-state: branch beats stall, stall beats advance; HALT freezes everything but ir_valid
  always_comb begin
    state_n = state;
    pc_n = pc;
    ir_n = ir;
    ir_pc_n = ir_pc;
    ir_valid_n = ir_valid;
    count_n = fetch_count;
    if (state == HALT) begin
      ir_valid_n = stall ? ir_valid : 1'b0;
    end else if (branch_en) begin
      pc_n = branch_addr;
      ir_valid_n = 1'b0;
    end else if (advance) begin
      ir_n = instr_in;
      ir_pc_n = pc;
      ir_valid_n = 1'b1;
      count_n = fetch_count == 16'hFFFF ? fetch_count : fetch_count + 16'd1;
      state_n = instr_in == HALT_WORD ? HALT : RUN;
      pc_n = instr_in == HALT_WORD ? pc : pc + 1'b1;
    end
  end
  // state register; halted trails entry into HALT by one edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_ADDR;
      ir <= '0;
      ir_pc <= '0;
      ir_valid <= 1'b0;
      halted <= 1'b0;
      fetch_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      ir <= ir_n;
      ir_pc <= ir_pc_n;
      ir_valid <= ir_valid_n;
      halted <= state == HALT;
      fetch_count <= count_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: table-driven scoreboard bench for instr_fetch against a behavioural ROM
module tb_instr_fetch;
  logic clk = 0, rst = 1, stall = 0, branch_en = 0;
  logic [11:0] instr_addr, branch_addr = '0, ir_pc;
  logic [15:0] instr_in, ir, fetch_count;
  logic ir_valid, halted;
  logic [15:0] mem [4096];
  int checks = 0, failures = 0;

  typedef struct {
    logic rst, stall, br;
    logic [11:0] baddr;
    logic [15:0] ir;
    logic [11:0] ir_pc;
    logic v, h;
    logic [15:0] cnt;
    logic [11:0] addr;
  } vec_t;
  vec_t vecs [35];
  vec_t sb [$];

  instr_fetch dut (
    .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_in(instr_in),
    .stall(stall), .branch_en(branch_en), .branch_addr(branch_addr),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  assign instr_in = mem[instr_addr];
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    vec_t e;
    rst = v.rst;
    stall = v.stall;
    branch_en = v.br;
    branch_addr = v.baddr;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("ir", idx, ir, e.ir);
    check("ir_pc", idx, {4'h0, ir_pc}, {4'h0, e.ir_pc});
    check("ir_valid", idx, {15'h0, ir_valid}, {15'h0, e.v});
    check("halted", idx, {15'h0, halted}, {15'h0, e.h});
    check("fetch_count", idx, fetch_count, e.cnt);
    check("instr_addr", idx, {4'h0, instr_addr}, {4'h0, e.addr});
    checks++;
    if ($isunknown(instr_addr)) begin
      failures++;
      $display("FAIL instr_addr_x step %0d: got %h expected known value", idx, instr_addr);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [11:0] ba,
                              input logic [15:0] i, input logic [11:0] p, input logic v,
                              input logic h, input logic [15:0] c, input logic [11:0] a);
    vec_t t;
    t.rst = r; t.stall = s; t.br = b; t.baddr = ba;
    t.ir = i; t.ir_pc = p; t.v = v; t.h = h; t.cnt = c; t.addr = a;
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    mem[0] = 16'h1000; mem[1] = 16'h2001; mem[2] = 16'h3002; mem[3] = 16'h4003;
    mem[5] = 16'hFFFF; mem[12'h040] = 16'hA5A5;
    mem[12'hFFE] = 16'hEEEE; mem[12'hFFF] = 16'hEFFF;
    //             rst stl br  baddr    ir        ir_pc   v  h  cnt  addr
    vecs[0]  = mk(1, 0, 0, 12'h000, 16'h0000, 12'h000, 0, 0, 0,  12'h000);
    vecs[1]  = mk(0, 0, 0, 12'h000, 16'h1000, 12'h000, 1, 0, 1,  12'h001);
    vecs[2]  = mk(0, 0, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 2,  12'h002);
    vecs[3]  = mk(0, 1, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 2,  12'h002);
    vecs[4]  = mk(0, 1, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 2,  12'h002);
    vecs[5]  = mk(0, 1, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 2,  12'h002);
    vecs[6]  = mk(0, 0, 0, 12'h000, 16'h3002, 12'h002, 1, 0, 3,  12'h003);
    vecs[7]  = mk(0, 0, 0, 12'h000, 16'h4003, 12'h003, 1, 0, 4,  12'h004);
    vecs[8]  = mk(0, 0, 1, 12'h040, 16'h4003, 12'h003, 0, 0, 4,  12'h040);
    vecs[9]  = mk(0, 0, 0, 12'h000, 16'hA5A5, 12'h040, 1, 0, 5,  12'h041);
    vecs[10] = mk(0, 1, 1, 12'h040, 16'hA5A5, 12'h040, 0, 0, 5,  12'h040);
    vecs[11] = mk(0, 1, 0, 12'h000, 16'hA5A5, 12'h040, 0, 0, 5,  12'h040);
    vecs[12] = mk(0, 0, 0, 12'h000, 16'hA5A5, 12'h040, 1, 0, 6,  12'h041);
    vecs[13] = mk(0, 0, 1, 12'hFFE, 16'hA5A5, 12'h040, 0, 0, 6,  12'hFFE);
    vecs[14] = mk(0, 0, 0, 12'h000, 16'hEEEE, 12'hFFE, 1, 0, 7,  12'hFFF);
    vecs[15] = mk(0, 0, 0, 12'h000, 16'hEFFF, 12'hFFF, 1, 0, 8,  12'h000);
    vecs[16] = mk(0, 0, 0, 12'h000, 16'h1000, 12'h000, 1, 0, 9,  12'h001);
    vecs[17] = mk(0, 0, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 10, 12'h002);
    vecs[18] = mk(0, 1, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 10, 12'h002);
    vecs[19] = mk(1, 1, 0, 12'h000, 16'h0000, 12'h000, 0, 0, 0,  12'h000);
    vecs[20] = mk(0, 0, 0, 12'h000, 16'h1000, 12'h000, 1, 0, 1,  12'h001);
    vecs[21] = mk(0, 0, 1, 12'h040, 16'h1000, 12'h000, 0, 0, 1,  12'h040);
    vecs[22] = mk(1, 0, 1, 12'h123, 16'h0000, 12'h000, 0, 0, 0,  12'h000);
    vecs[23] = mk(0, 0, 0, 12'h000, 16'h1000, 12'h000, 1, 0, 1,  12'h001);
    vecs[24] = mk(0, 0, 0, 12'h000, 16'h2001, 12'h001, 1, 0, 2,  12'h002);
    vecs[25] = mk(0, 0, 0, 12'h000, 16'h3002, 12'h002, 1, 0, 3,  12'h003);
    vecs[26] = mk(0, 0, 0, 12'h000, 16'h4003, 12'h003, 1, 0, 4,  12'h004);
    vecs[27] = mk(0, 0, 0, 12'h000, 16'h0004, 12'h004, 1, 0, 5,  12'h005);
    vecs[28] = mk(0, 0, 0, 12'h000, 16'hFFFF, 12'h005, 1, 0, 6,  12'h005);
    vecs[29] = mk(0, 1, 0, 12'h000, 16'hFFFF, 12'h005, 1, 1, 6,  12'h005);
    vecs[30] = mk(0, 0, 1, 12'h040, 16'hFFFF, 12'h005, 0, 1, 6,  12'h005);
    vecs[31] = mk(0, 0, 1, 12'h040, 16'hFFFF, 12'h005, 0, 1, 6,  12'h005);
    vecs[32] = mk(0, 0, 0, 12'h000, 16'hFFFF, 12'h005, 0, 1, 6,  12'h005);
    vecs[33] = mk(1, 0, 0, 12'h000, 16'h0000, 12'h000, 0, 0, 0,  12'h000);
    vecs[34] = mk(0, 0, 0, 12'h000, 16'h1000, 12'h000, 1, 0, 1,  12'h001);
    @(posedge clk);
    #1;
    for (int i = 0; i < 35; i++) step(i, vecs[i]);
    // HALT word seen during branch and stall cycles must not halt; only a real advance captures it
    step(100, mk(0, 1, 1, 12'h005, 16'h1000, 12'h000, 0, 0, 1, 12'h005));
    step(101, mk(0, 1, 0, 12'h000, 16'h1000, 12'h000, 0, 0, 1, 12'h005));
    step(102, mk(0, 0, 1, 12'h005, 16'h1000, 12'h000, 0, 0, 1, 12'h005));
    step(103, mk(0, 0, 0, 12'h000, 16'hFFFF, 12'h005, 1, 0, 2, 12'h005));
    step(104, mk(0, 0, 0, 12'h000, 16'hFFFF, 12'h005, 0, 1, 2, 12'h005));
    step(105, mk(0, 0, 0, 12'h000, 16'hFFFF, 12'h005, 0, 1, 2, 12'h005));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
